zion_riscv_addsub_pipe: RTL and testbench
=========================================

Name: zion_riscv_addsub_pipe

Overview:
Parametrised, pipelined RISC-V add/sub/compare execution unit for XLEN 32 or 64. It covers ADD/SUB, RV64 word ops (ADDW/SUBW), SLT/SLTU and the six branch compares. It sits between issue and writeback, with a valid/ready handshake on both sides, backpressure, flush and an opaque tag carried alongside each operation. It replaces the single-cycle combinational add/sub + less-than pair with one unit of configurable depth.

Parameters:
XLEN, 32, datapath width; legal values 32 and 64 only, anything else is an elaboration $error
STAGES, 1, pipeline depth in cycles from input handshake to output valid; legal range 1..4
TAG_W, 4, width of the pass-through tag

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operation offered
in_ready  output  1  unit accepts an operation this cycle
in_op  input  4  operation code (encoding in the shared package)
in_s1  input  XLEN  operand 1
in_s2  input  XLEN  operand 2
in_tag  input  TAG_W  opaque tag, returned unchanged
flush  input  1  kill all in-flight operations
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_rslt  output  XLEN  arithmetic / set-less-than result
out_cond  output  1  branch-condition result (0 for non-branch ops)
out_illegal  output  1  op not supported for this XLEN
out_tag  output  TAG_W  tag of the presented result

Behaviour:
- Reset (rst=1 at a posedge): every stage valid bit cleared. out_valid=0, out_rslt=0, out_cond=0, out_illegal=0, out_tag=0. Reset mid-operation discards all in-flight ops. in_ready=1 in the first cycle after reset.
- Handshake: transfer when valid&&ready on the same posedge. Stage k advances when it is empty or stage k+1 advances; the last stage advances when out_ready. in_ready = stage-1 advance condition, so bubbles collapse. Full throughput is 1 op/cycle with out_ready held high.
- Latency is exactly STAGES cycles with no stall: op accepted at edge N gives out_valid=1 after edge N+STAGES-1 (STAGES=1 means visible after the accepting edge).
- out_valid, out_rslt, out_cond, out_illegal and out_tag stay stable while out_valid && !out_ready.
- All arithmetic is computed combinationally from the inputs and captured into stage 1. Stages 2..STAGES are delay/skid registers. Data registers load only on an advancing valid; stale data is allowed when valid=0.
- Arithmetic core: a single (XLEN+1)-bit adder sum = {0,s1} + {0,s2^{XLEN{sub}}} + sub, where sub=1 for every op except ADD/ADDW.
  - carry = sum[XLEN].
  - ltu = !carry.
  - lt = sum[XLEN-1] ^ ovf, with ovf = (s1[msb]^s2[msb]) & (s1[msb]^sum[XLEN-1]).
  - eq = (s1==s2).
- Ops:
  - ADD/SUB: rslt = sum[XLEN-1:0], wrap-around with no trap.
  - ADDW/SUBW: rslt = sign-extend(sum[31:0]) to 64 bits.
  - SLT/SLTU: rslt = {0..,lt} / {0..,ltu}.
  - BEQ/BNE/BLT/BGE/BLTU/BGEU: cond = eq, !eq, lt, !lt, ltu, !ltu; rslt = sum.
- Illegal: ADDW/SUBW when XLEN=32, or any unused encoding. The op still flows through the pipe with rslt=0, cond=0, illegal=1, and keeps its original latency.
- flush=1 at a posedge clears all stage valid bits, including an op accepted on that same edge (in_ready is not gated by flush). out_valid=0 on the next cycle. flush together with out_ready: the output op is considered consumed, and no duplicate is presented.
- Simultaneous accept and emit while full: allowed, and occupancy is unchanged.

Decomposition:
- Package zion_riscv_addsub_pkg holds:
  - typedef enum logic [3:0] op_e: ADD=0, SUB=1, ADDW=2, SUBW=3, SLT=4, SLTU=5, BEQ=8, BNE=9, BLT=10, BGE=11, BLTU=12, BGEU=13; all other encodings illegal.
  - Function is_sub(op_e).
  - Function is_branch(op_e).
  - Stage payload struct template: rslt, cond, illegal, tag (parametrised by XLEN/TAG_W through the module).
- Sub-module zion_riscv_addsub_core: purely combinational; takes op,s1,s2 and returns rslt,cond,illegal. It is instantiated once, ahead of stage 1. The pipe/handshake logic stays in the top module as a generate loop over STAGES.

Test Plan:
- XLEN=32,STAGES=1: ADD 0xFFFFFFFF+1 -> rslt=0x0 one cycle later; SUB 0x0-1 -> 0xFFFFFFFF; ADDW -> illegal=1, rslt=0.
- XLEN=64: ADDW s1=0x7FFFFFFF,s2=1 -> rslt=0xFFFFFFFF80000000; SUBW s1=0x1_00000000,s2=1 -> 0xFFFFFFFFFFFFFFFF.
- XLEN=32: SLT s1=0x80000000,s2=1 -> 1, SLTU same operands -> 0; BGE s1=0x7FFFFFFF,s2=0x80000000 -> cond=1; BEQ 5,5 -> cond=1; BLTU 5,5 -> cond=0.
- STAGES=3, out_ready held 0 for 5 cycles while 4 ops are offered -> exactly 3 accepted, in_ready=0 on the 4th, outputs stable. Releasing out_ready drains tags in order 0,1,2 with no loss or duplicate.
- STAGES=2, back-to-back random ops, out_ready=1 for 200 cycles -> 1 op/cycle, each result matches the reference model 2 cycles after accept, tags in order.
- flush asserted on the same edge as an accept with 2 ops in flight -> out_valid=0 the next cycle and none of the 3 tags ever appears. rst asserted mid-stream -> all outputs 0, in_ready=1 the next cycle.

Source files
------------

// File: rtl/zion_riscv_addsub_pkg.sv
// Shared definitions for the add/sub/compare execution unit: operation
// encoding and small decode helpers used by the core and the bench.
package zion_riscv_addsub_pkg;

  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    ADDW = 4'd2,
    SUBW = 4'd3,
    SLT  = 4'd4,
    SLTU = 4'd5,
    BEQ  = 4'd8,
    BNE  = 4'd9,
    BLT  = 4'd10,
    BGE  = 4'd11,
    BLTU = 4'd12,
    BGEU = 4'd13
  } op_e;

  localparam int OP_W = 4;

  // Every op subtracts except the two plain additions; compares need s1-s2.
  function automatic logic is_sub(op_e op);
    return !(op == ADD || op == ADDW);
  endfunction

  // Branch compares return the raw difference as rslt and a condition bit.
  function automatic logic is_branch(op_e op);
    return (op == BEQ) || (op == BNE) || (op == BLT) ||
           (op == BGE) || (op == BLTU) || (op == BGEU);
  endfunction

endpackage

// File: rtl/zion_riscv_addsub_core.sv
// Combinational arithmetic core: one shared (XLEN+1)-bit adder produces the
// sum, carry and signed/unsigned less-than used by every operation.
module zion_riscv_addsub_core
  import zion_riscv_addsub_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [OP_W-1:0] op,
  input  logic [XLEN-1:0] s1,
  input  logic [XLEN-1:0] s2,
  output logic [XLEN-1:0] rslt,
  output logic            cond,
  output logic            illegal
);

  op_e             opc;
  logic            sub;
  logic [XLEN:0]   sum;
  logic            ltu;
  logic            ovf;
  logic            lt;
  logic            eq;
  logic [XLEN-1:0] wext;

  assign opc = op_e'(op);
  assign sub = is_sub(opc);
  assign sum = {1'b0, s1} + {1'b0, s2 ^ {XLEN{sub}}} + {{XLEN{1'b0}}, sub};
  assign ltu = !sum[XLEN];
  assign ovf = (s1[XLEN-1] ^ s2[XLEN-1]) & (s1[XLEN-1] ^ sum[XLEN-1]);
  assign lt  = sum[XLEN-1] ^ ovf;
  assign eq  = (s1 == s2);

  // Word ops keep the low 32 bits of the sum and sign-extend them to XLEN.
  always_comb begin
    wext       = {XLEN{sum[31]}};
    wext[31:0] = sum[31:0];
  end

  // Select the result per op; illegal ops report zero data and the flag.
  always_comb begin
    rslt    = '0;
    cond    = 1'b0;
    illegal = 1'b0;
    case (opc)
      ADD, SUB:   rslt = sum[XLEN-1:0];
      ADDW, SUBW: begin
        if (XLEN == 32) illegal = 1'b1;
        else            rslt    = wext;
      end
      SLT:        rslt = {{(XLEN-1){1'b0}}, lt};
      SLTU:       rslt = {{(XLEN-1){1'b0}}, ltu};
      BEQ:        cond = eq;
      BNE:        cond = !eq;
      BLT:        cond = lt;
      BGE:        cond = !lt;
      BLTU:       cond = ltu;
      BGEU:       cond = !ltu;
      default:    illegal = 1'b1;
    endcase
    if (is_branch(opc)) rslt = sum[XLEN-1:0];
  end

endmodule

// File: rtl/zion_riscv_addsub_pipe.sv
// Pipelined add/sub/compare unit. The core result is captured into stage 1;
// later stages are delay registers with per-stage valid/ready so bubbles
// collapse and the unit sustains one op per cycle.
module zion_riscv_addsub_pipe
  import zion_riscv_addsub_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAGES = 1,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [XLEN-1:0]  in_s1,
  input  logic [XLEN-1:0]  in_s2,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_rslt,
  output logic             out_cond,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("zion_riscv_addsub_pipe: XLEN must be 32 or 64");
  end
  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("zion_riscv_addsub_pipe: STAGES must be in 1..4");
  end

  typedef struct packed {
    logic [XLEN-1:0]  rslt;
    logic             cond;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } stage_t;

  logic [XLEN-1:0] core_rslt;
  logic            core_cond;
  logic            core_illegal;
  stage_t          core_d;

  stage_t pl  [STAGES];
  logic   vld [STAGES];
  logic   adv [STAGES];

  zion_riscv_addsub_core #(.XLEN(XLEN)) u_core (
    .op      (in_op),
    .s1      (in_s1),
    .s2      (in_s2),
    .rslt    (core_rslt),
    .cond    (core_cond),
    .illegal (core_illegal)
  );

  assign core_d = '{rslt: core_rslt, cond: core_cond,
                    illegal: core_illegal, tag: in_tag};

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic   in_v;
    stage_t in_d;
    logic   vld_q;
    stage_t pl_q;

    if (k == 0) begin : g_first
      assign in_v = in_valid;
      assign in_d = core_d;
    end else begin : g_mid
      assign in_v = vld[k-1];
      assign in_d = pl[k-1];
    end

    if (k == STAGES - 1) begin : g_last
      assign adv[k] = !vld_q || out_ready;
    end else begin : g_inner
      assign adv[k] = !vld_q || adv[k+1];
    end

    // Valid bit: cleared by reset or flush, otherwise follows the upstream stage on advance.
    always_ff @(posedge clk) begin
      if (rst)         vld_q <= 1'b0;
      else if (flush)  vld_q <= 1'b0;
      else if (adv[k]) vld_q <= in_v;
    end

    // Payload only loads when a valid op moves in; stale data is harmless behind vld_q.
    always_ff @(posedge clk) begin
      if (adv[k] && in_v) pl_q <= in_d;
    end

    assign vld[k] = vld_q;
    assign pl[k]  = pl_q;
  end

  assign in_ready    = adv[0];
  assign out_valid   = vld[STAGES-1];
  assign out_rslt    = vld[STAGES-1] ? pl[STAGES-1].rslt    : '0;
  assign out_cond    = vld[STAGES-1] ? pl[STAGES-1].cond    : 1'b0;
  assign out_illegal = vld[STAGES-1] ? pl[STAGES-1].illegal : 1'b0;
  assign out_tag     = vld[STAGES-1] ? pl[STAGES-1].tag     : '0;

endmodule

// File: tb/tb_zion_riscv_addsub_pipe.sv
// Scoreboard bench: instance A is XLEN=32/STAGES=3, instance B is
// XLEN=64/STAGES=2. Accepted ops push expected results; per-instance
// monitors pop and compare whenever a result is handed over.
module tb_zion_riscv_addsub_pipe;
  import zion_riscv_addsub_pkg::*;

  localparam int SA = 3;
  localparam int SB = 2;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   vectors = 0;
  int   errors = 0;
  bit   lat_on;

  logic        a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
  logic [3:0]  a_in_op, a_in_tag, a_out_tag;
  logic [31:0] a_in_s1, a_in_s2, a_out_rslt;
  logic        a_out_cond, a_out_illegal;

  logic        b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
  logic [3:0]  b_in_op, b_in_tag, b_out_tag;
  logic [63:0] b_in_s1, b_in_s2, b_out_rslt;
  logic        b_out_cond, b_out_illegal;

  typedef struct {
    logic [63:0] rslt;
    logic        cond;
    logic        ill;
    logic [3:0]  tag;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  typedef struct packed {
    logic [3:0]  op;
    logic [63:0] s1;
    logic [63:0] s2;
    logic [63:0] er;
    logic        ec;
    logic        ei;
  } vec_t;

  vec_t va [14] = '{
    '{ADD,  64'hFFFF_FFFF, 64'h1,          64'h0,         1'b0, 1'b0},
    '{SUB,  64'h0,         64'h1,          64'hFFFF_FFFF, 1'b0, 1'b0},
    '{ADDW, 64'h5,         64'h3,          64'h0,         1'b0, 1'b1},
    '{SLT,  64'h8000_0000, 64'h1,          64'h1,         1'b0, 1'b0},
    '{SLTU, 64'h8000_0000, 64'h1,          64'h0,         1'b0, 1'b0},
    '{BGE,  64'h7FFF_FFFF, 64'h8000_0000,  64'hFFFF_FFFF, 1'b1, 1'b0},
    '{BEQ,  64'h5,         64'h5,          64'h0,         1'b1, 1'b0},
    '{BLTU, 64'h5,         64'h5,          64'h0,         1'b0, 1'b0},
    '{4'd7, 64'h1,         64'h2,          64'h0,         1'b0, 1'b1},
    '{BLT,  64'h8000_0000, 64'h1,          64'h7FFF_FFFF, 1'b1, 1'b0},
    '{BNE,  64'h3,         64'h4,          64'hFFFF_FFFF, 1'b1, 1'b0},
    '{BGEU, 64'h8000_0000, 64'h1,          64'h7FFF_FFFF, 1'b1, 1'b0},
    '{SUBW, 64'h1,         64'h1,          64'h0,         1'b0, 1'b1},
    '{ADD,  64'h7FFF_FFFF, 64'h1,          64'h8000_0000, 1'b0, 1'b0}
  };

  vec_t vb [13] = '{
    '{ADDW, 64'h7FFF_FFFF,           64'h1,                   64'hFFFF_FFFF_8000_0000, 1'b0, 1'b0},
    '{SUBW, 64'h1_0000_0000,         64'h1,                   64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0},
    '{ADD,  64'hFFFF_FFFF_FFFF_FFFF, 64'h1,                   64'h0,                   1'b0, 1'b0},
    '{SLT,  64'h8000_0000_0000_0000, 64'h1,                   64'h1,                   1'b0, 1'b0},
    '{SLTU, 64'h8000_0000_0000_0000, 64'h1,                   64'h0,                   1'b0, 1'b0},
    '{SUB,  64'h0,                   64'h1,                   64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0},
    '{ADDW, 64'hFFFF_FFFF_0000_0005, 64'h3,                   64'h8,                   1'b0, 1'b0},
    '{BLT,  64'h1,                   64'h2,                   64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0},
    '{BGE,  64'h2,                   64'h1,                   64'h1,                   1'b1, 1'b0},
    '{4'd15, 64'h1,                  64'h2,                   64'h0,                   1'b0, 1'b1},
    '{BEQ,  64'h7,                   64'h8,                   64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0},
    '{BGEU, 64'h1,                   64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 1'b0, 1'b0},
    '{SUBW, 64'h8000_0000,           64'h1,                   64'h7FFF_FFFF,           1'b0, 1'b0}
  };

  zion_riscv_addsub_pipe #(.XLEN(32), .STAGES(SA), .TAG_W(4)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_op(a_in_op),
    .in_s1(a_in_s1), .in_s2(a_in_s2), .in_tag(a_in_tag), .flush(a_flush),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_rslt(a_out_rslt),
    .out_cond(a_out_cond), .out_illegal(a_out_illegal), .out_tag(a_out_tag)
  );

  zion_riscv_addsub_pipe #(.XLEN(64), .STAGES(SB), .TAG_W(4)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_op(b_in_op),
    .in_s1(b_in_s1), .in_s2(b_in_s2), .in_tag(b_in_tag), .flush(b_flush),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_rslt(b_out_rslt),
    .out_cond(b_out_cond), .out_illegal(b_out_illegal), .out_tag(b_out_tag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Offer one op to instance A (sel=0) or B (sel=1); push its expected
  // result on the edge it is accepted. Returns with in_valid still high.
  task automatic applyStimulus(input bit sel, input logic [3:0] op,
                               input logic [63:0] s1, input logic [63:0] s2,
                               input logic [3:0] tag, input logic [63:0] er,
                               input logic ec, input logic ei, output int waited);
    exp_t e;
    bit   acc;
    acc    = 1'b0;
    waited = 0;
    if (sel) begin
      b_in_valid = 1'b1; b_in_op = op; b_in_s1 = s1; b_in_s2 = s2; b_in_tag = tag;
    end else begin
      a_in_valid = 1'b1; a_in_op = op; a_in_s1 = s1[31:0]; a_in_s2 = s2[31:0]; a_in_tag = tag;
    end
    while (!acc && waited < 40) begin
      @(negedge clk);
      if ((sel ? b_in_ready : a_in_ready) === 1'b1) begin
        e.rslt = er; e.cond = ec; e.ill = ei; e.tag = tag;
        e.cyc  = cyc + (sel ? SB : SA);
        e.lat  = lat_on;
        if (sel) qb.push_back(e);
        else     qa.push_back(e);
        acc = 1'b1;
      end else begin
        waited++;
      end
    end
    if (!acc) checkOutput(sel ? "b_accept_timeout" : "a_accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    if (!acc) begin
      if (sel) b_in_valid = 1'b0;
      else     a_in_valid = 1'b0;
    end
  endtask

  task automatic waitDrain();
    for (int n = 0; n < 40 && (qa.size() != 0 || qb.size() != 0); n++) @(posedge clk);
    #1;
    checkOutput("drain_queues_empty", 64'(qa.size() + qb.size()), 64'd0);
  endtask

  // Monitor for instance A: compare every handed-over result with the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && a_flush === 1'b0 && a_out_valid === 1'b1 && a_out_ready === 1'b1) begin
      if (qa.size() == 0) begin
        vectors++;
        errors++;
        $display("[TB] FAIL a_unexpected_output: got tag %0d, expected no output", a_out_tag);
      end else begin
        e = qa.pop_front();
        checkOutput("a_rslt", {32'd0, a_out_rslt}, e.rslt);
        checkOutput("a_cond_ill_tag", {58'd0, a_out_cond, a_out_illegal, a_out_tag},
                    {58'd0, e.cond, e.ill, e.tag});
        if (e.lat) checkOutput("a_latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Monitor for instance B: same scoreboard discipline as A.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && b_flush === 1'b0 && b_out_valid === 1'b1 && b_out_ready === 1'b1) begin
      if (qb.size() == 0) begin
        vectors++;
        errors++;
        $display("[TB] FAIL b_unexpected_output: got tag %0d, expected no output", b_out_tag);
      end else begin
        e = qb.pop_front();
        checkOutput("b_rslt", b_out_rslt, e.rslt);
        checkOutput("b_cond_ill_tag", {58'd0, b_out_cond, b_out_illegal, b_out_tag},
                    {58'd0, e.cond, e.ill, e.tag});
        if (e.lat) checkOutput("b_latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    int w;
    rst = 1'b1; lat_on = 1'b1;
    a_in_valid = 1'b0; a_in_op = '0; a_in_s1 = '0; a_in_s2 = '0; a_in_tag = '0;
    a_flush = 1'b0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_op = '0; b_in_s1 = '0; b_in_s2 = '0; b_in_tag = '0;
    b_flush = 1'b0; b_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    checkOutput("reset_a_out_valid", {63'd0, a_out_valid}, 64'd0);
    checkOutput("reset_a_out_rslt", {32'd0, a_out_rslt}, 64'd0);
    checkOutput("reset_a_flags", {58'd0, a_out_cond, a_out_illegal, a_out_tag}, 64'd0);
    checkOutput("reset_a_in_ready", {63'd0, a_in_ready}, 64'd1);
    checkOutput("reset_b_out_valid", {63'd0, b_out_valid}, 64'd0);
    checkOutput("reset_b_in_ready", {63'd0, b_in_ready}, 64'd1);
    @(posedge clk);
    #1;

    $display("[TB] directed vectors, XLEN=32 STAGES=3");
    for (int i = 0; i < 14; i++)
      applyStimulus(1'b0, va[i].op, va[i].s1, va[i].s2, 4'(i), va[i].er, va[i].ec, va[i].ei, w);
    a_in_valid = 1'b0;

    $display("[TB] back-to-back vectors, XLEN=64 STAGES=2");
    for (int i = 0; i < 13; i++) begin
      applyStimulus(1'b1, vb[i].op, vb[i].s1, vb[i].s2, 4'(i), vb[i].er, vb[i].ec, vb[i].ei, w);
      checkOutput("b_accept_stall", 64'(w), 64'd0);
    end
    b_in_valid = 1'b0;
    waitDrain();

    $display("[TB] backpressure on A");
    a_out_ready = 1'b0;
    lat_on = 1'b0;
    applyStimulus(1'b0, ADD,  64'd1,  64'd2, 4'd0, 64'd3, 1'b0, 1'b0, w);
    checkOutput("bp_accept0_stall", 64'(w), 64'd0);
    applyStimulus(1'b0, SUB,  64'd10, 64'd4, 4'd1, 64'd6, 1'b0, 1'b0, w);
    checkOutput("bp_accept1_stall", 64'(w), 64'd0);
    applyStimulus(1'b0, SLTU, 64'd1,  64'd2, 4'd2, 64'd1, 1'b0, 1'b0, w);
    checkOutput("bp_accept2_stall", 64'(w), 64'd0);
    a_in_op = ADD; a_in_s1 = 32'd9; a_in_s2 = 32'd9; a_in_tag = 4'd3;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      checkOutput("bp_in_ready_low", {63'd0, a_in_ready}, 64'd0);
      checkOutput("bp_out_valid_held", {63'd0, a_out_valid}, 64'd1);
      checkOutput("bp_out_tag_held", {60'd0, a_out_tag}, 64'd0);
      checkOutput("bp_out_rslt_held", {32'd0, a_out_rslt}, 64'd3);
    end
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    waitDrain();
    lat_on = 1'b1;

    $display("[TB] flush on A with two ops in flight");
    applyStimulus(1'b0, ADD, 64'd1, 64'd1, 4'd4, 64'd2, 1'b0, 1'b0, w);
    applyStimulus(1'b0, ADD, 64'd2, 64'd2, 4'd5, 64'd4, 1'b0, 1'b0, w);
    a_in_op = ADD; a_in_s1 = 32'd3; a_in_s2 = 32'd3; a_in_tag = 4'd6;
    a_flush = 1'b1;
    @(negedge clk);
    checkOutput("flush_in_ready", {63'd0, a_in_ready}, 64'd1);
    @(posedge clk);
    qa.delete();
    #1;
    a_flush = 1'b0;
    a_in_valid = 1'b0;
    @(negedge clk);
    checkOutput("flush_out_valid", {63'd0, a_out_valid}, 64'd0);
    repeat (6) @(posedge clk);
    #1;

    $display("[TB] reset mid-stream");
    applyStimulus(1'b0, ADD, 64'd5, 64'd6, 4'd7, 64'd11, 1'b0, 1'b0, w);
    applyStimulus(1'b0, ADD, 64'd1, 64'd1, 4'd8, 64'd2,  1'b0, 1'b0, w);
    applyStimulus(1'b0, ADD, 64'd2, 64'd2, 4'd9, 64'd4,  1'b0, 1'b0, w);
    a_in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("pre_reset_out_valid", {63'd0, a_out_valid}, 64'd1);
    @(posedge clk);
    qa.delete();
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_out_valid", {63'd0, a_out_valid}, 64'd0);
    checkOutput("rst_mid_out_rslt", {32'd0, a_out_rslt}, 64'd0);
    checkOutput("rst_mid_flags", {58'd0, a_out_cond, a_out_illegal, a_out_tag}, 64'd0);
    checkOutput("rst_mid_in_ready", {63'd0, a_in_ready}, 64'd1);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, SUB, 64'd9, 64'd4, 4'd10, 64'd5, 1'b0, 1'b0, w);
    a_in_valid = 1'b0;
    repeat (6) @(posedge clk);
    waitDrain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
